// File: rtl/seq_event_logger.sv
// Event logger: timestamps rising edges of an upstream detection flag and
// queues them in a small first-word-fall-through FIFO for a consumer.
module seq_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     output_indicator,
  input  logic                     rd_ack,
  input  logic                     clear,
  output logic                     ev_valid,
  output logic [TS_W-1:0]          ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic [15:0]              hit_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic            ind_q;
  logic [TS_W-1:0] ts;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TS_W-1:0] mem [DEPTH];

  logic event_hit;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  // A full FIFO still accepts a new event when the head leaves in the same cycle.
  always_comb begin
    event_hit = output_indicator & ~ind_q;
    full      = (ev_count == FULL_CNT);
    do_pop    = rd_ack & ev_valid;
    do_push   = event_hit & (~full | do_pop);
    drop      = event_hit & full & ~do_pop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ind_q     <= 1'b0;
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ev_count  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      ind_q <= output_indicator;
      if (clear) begin
        ts        <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        ev_count  <= '0;
        hit_count <= '0;
        overflow  <= 1'b0;
      end else begin
        ts <= ts + TS_W'(1);
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)
          ev_count <= ev_count + (AW+1)'(1);
        else if (do_pop && !do_push)
          ev_count <= ev_count - (AW+1)'(1);
        if (event_hit && hit_count != 16'hFFFF)
          hit_count <= hit_count + 16'd1;
        if (drop)
          overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the empty-gating on ev_data hides stale entries.
  always_ff @(posedge clock) begin
    if (!clear && do_push)
      mem[wr_ptr] <= ts;
  end

  assign ev_valid = (ev_count != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_seq_event_logger.sv
// Self-checking bench for seq_event_logger: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_seq_event_logger;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            output_indicator;
  logic            rd_ack;
  logic            clear;
  logic            ev_valid;
  logic [TS_W-1:0] ev_data;
  logic [CW-1:0]   ev_count;
  logic [15:0]     hit_count;
  logic            overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int m_q[$];
  int m_ts;
  int m_hits;
  bit m_ind_q;
  bit m_ovf;

  seq_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clock(clock),
    .reset(reset),
    .output_indicator(output_indicator),
    .rd_ack(rd_ack),
    .clear(clear),
    .ev_valid(ev_valid),
    .ev_data(ev_data),
    .ev_count(ev_count),
    .hit_count(hit_count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts    = 0;
    m_hits  = 0;
    m_ind_q = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the logger, described in terms of queue operations.
  task automatic model_edge(input bit ind, input bit ack, input bit clr);
    bit ev;
    ev = ind && !m_ind_q;
    if (clr) begin
      m_q.delete();
      m_hits = 0;
      m_ovf  = 1'b0;
      m_ts   = 0;
    end else begin
      if (ack && m_q.size() > 0) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_ts);
        else m_ovf = 1'b1;
        if (m_hits < 65535) m_hits++;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    m_ind_q = ind;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ev_valid"},  32'(ev_valid),  32'(m_q.size() != 0));
    check({tag, ".ev_data"},   32'(ev_data),   (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check({tag, ".ev_count"},  32'(ev_count),  32'(m_q.size()));
    check({tag, ".hit_count"}, 32'(hit_count), 32'(m_hits));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic tick(input bit ind, input bit ack, input bit clr, input string tag);
    output_indicator = ind;
    rd_ack           = ack;
    clear            = clr;
    @(posedge clock);
    model_edge(ind, ack, clr);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset            = 1'b1;
    output_indicator = 1'b0;
    rd_ack           = 1'b0;
    clear            = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // First detection lands on the edge where the timestamp reads 3.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, "pre028");
    tick(1'b1, 1'b0, 1'b0, "req028");
    check("req028.data3", 32'(ev_data), 32'd3);
    check("req028.count1", 32'(ev_count), 32'd1);
    check("req028.hits1", 32'(hit_count), 32'd1);

    // A long high run counts as a single event.
    tick(1'b0, 1'b0, 1'b1, "clr029");
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, "req029hi");
    tick(1'b0, 1'b0, 1'b0, "req029lo");
    check("req029.count1", 32'(ev_count), 32'd1);
    check("req029.hits1", 32'(hit_count), 32'd1);

    // Five events into a four-deep FIFO: last one dropped, overflow sticks.
    tick(1'b0, 1'b0, 1'b1, "clr030");
    for (int t = 0; t < 15; t++) tick((t % 3) == 2, 1'b0, 1'b0, "req030fill");
    tick(1'b0, 1'b0, 1'b0, "req030idle");
    check("req030.count4", 32'(ev_count), 32'd4);
    check("req030.ovf", 32'(overflow), 32'd1);
    check("req030.hits5", 32'(hit_count), 32'd5);
    for (int k = 0; k < 4; k++) begin
      check("req030.order", 32'(ev_data), 32'(2 + 3 * k));
      tick(1'b0, 1'b1, 1'b0, "req030pop");
    end
    check("req030.empty", 32'(ev_valid), 32'd0);

    // Push and pop on a full FIFO in the same cycle.
    tick(1'b0, 1'b0, 1'b1, "clr031");
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0, "req031push");
      tick(1'b0, 1'b0, 1'b0, "req031gap");
    end
    tick(1'b1, 1'b1, 1'b0, "req031both");
    check("req031.count4", 32'(ev_count), 32'd4);
    check("req031.noovf", 32'(overflow), 32'd0);
    check("req031.head", 32'(ev_data), 32'd2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, "req031drain");
    check("req031.last", 32'(ev_data), 32'd8);

    // Clear wins over a simultaneous event and restarts the timestamp.
    tick(1'b1, 1'b0, 1'b1, "req032");
    check("req032.count0", 32'(ev_count), 32'd0);
    check("req032.hits0", 32'(hit_count), 32'd0);
    tick(1'b0, 1'b0, 1'b0, "req032lo");
    tick(1'b1, 1'b0, 1'b0, "req032ev");
    check("req032.ts_restart", 32'(ev_data), 32'd1);

    // Build up three entries and seven hits, then reset asynchronously.
    tick(1'b0, 1'b0, 1'b1, "clr033");
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b0, 1'b0, "req033ev");
      tick(1'b0, i < 4, 1'b0, "req033ack");
    end
    check("req033.count3", 32'(ev_count), 32'd3);
    check("req033.hits7", 32'(hit_count), 32'd7);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("req033async");
    @(negedge clock);
    reset = 1'b0;

    // Timestamp wrap seen in the pushed values.
    for (int i = 0; i < 254; i++) tick(1'b0, 1'b0, 1'b0, "wrapidle");
    tick(1'b1, 1'b0, 1'b0, "wrap254");
    tick(1'b0, 1'b0, 1'b0, "wrap255");
    tick(1'b1, 1'b0, 1'b0, "wrap0");
    check("wrap.head254", 32'(ev_data), 32'd254);
    tick(1'b0, 1'b1, 1'b0, "wrappop");
    check("wrap.head0", 32'(ev_data), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      bit r_ind;
      bit r_ack;
      bit r_clr;
      r_ind = ($urandom_range(0, 2) == 0) ? ~output_indicator : output_indicator;
      r_ack = ($urandom_range(0, 3) == 0);
      r_clr = ($urandom_range(0, 59) == 0);
      tick(r_ind, r_ack, r_clr, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
